pipe_stage_hs: RTL and testbench



---
 rtl/pipe_stage_hs_pkg.sv | 16 +
 rtl/pipe_stage_hs.sv | 110 +++++++++++
 tb/tb_pipe_stage_hs.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the handshaked inter-stage pipeline register.
package pipe_stage_hs_pkg;

  localparam logic [31:0] DEF_NOP_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INS = 32'h0000_0013;  // addi x0,x0,0

  localparam logic RST_ACT   = 1'b0;
  localparam logic FLUSH_ACT = 1'b1;
  localparam logic RDY_ACT   = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } stage_beat_t;

endpackage

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register for a pc/instruction beat; 1-cycle latency, full throughput.
// SKID=1 adds a skid entry so up_ready is registered; SKID=0 uses a single entry.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int              PC_W    = 32,
  parameter int              INS_W   = 32,
  parameter logic [PC_W-1:0] NOP_PC  = DEF_NOP_PC,
  parameter logic [INS_W-1:0] NOP_INS = DEF_NOP_INS,
  parameter bit              SKID    = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [PC_W-1:0]  up_pc,
  input  logic [INS_W-1:0] up_ins,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [PC_W-1:0]  dn_pc,
  output logic [INS_W-1:0] dn_ins,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } beat_t;

  localparam beat_t NOP_BEAT = '{pc: NOP_PC, ins: NOP_INS};

  logic  m_vld, m_vld_d, s_vld, s_vld_d;
  beat_t m_dat, m_dat_d, s_dat, s_dat_d, up_dat;
  logic  up_fire, dn_fire;

  assign up_dat  = '{pc: up_pc, ins: up_ins};
  assign up_fire = up_valid & up_ready & (rdy_in == RDY_ACT);
  assign dn_fire = m_vld & dn_ready & (rdy_in == RDY_ACT);

  // Payloads are rewritten to NOP whenever an entry empties, so outputs come straight from flops.
  always_comb begin
    m_vld_d = m_vld;
    m_dat_d = m_dat;
    s_vld_d = s_vld;
    s_dat_d = s_dat;
    if (flush == FLUSH_ACT) begin
      m_vld_d = 1'b0;
      m_dat_d = NOP_BEAT;
      s_vld_d = 1'b0;
      s_dat_d = NOP_BEAT;
    end else if (rdy_in == RDY_ACT) begin
      if (!m_vld) begin
        if (up_fire) begin
          m_vld_d = 1'b1;
          m_dat_d = up_dat;
        end
      end else if (dn_fire) begin
        s_vld_d = 1'b0;
        s_dat_d = NOP_BEAT;
        if (s_vld) begin
          m_dat_d = s_dat;
        end else if (up_fire) begin
          m_dat_d = up_dat;
        end else begin
          m_vld_d = 1'b0;
          m_dat_d = NOP_BEAT;
        end
      end else if (up_fire) begin
        // Only reachable with a skid entry: single-entry up_ready is low here.
        s_vld_d = 1'b1;
        s_dat_d = up_dat;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ACT) begin
      m_vld <= 1'b0;
      m_dat <= NOP_BEAT;
    end else begin
      m_vld <= m_vld_d;
      m_dat <= m_dat_d;
    end
  end

  if (SKID) begin : g_skid
    always_ff @(posedge clk_in) begin
      if (rst_in == RST_ACT) begin
        s_vld <= 1'b0;
        s_dat <= NOP_BEAT;
      end else begin
        s_vld <= s_vld_d;
        s_dat <= s_dat_d;
      end
    end
    assign up_ready = ~s_vld;
  end else begin : g_single
    assign s_vld    = 1'b0;
    assign s_dat    = NOP_BEAT;
    assign up_ready = ~m_vld | dn_ready;
  end

  assign dn_valid  = m_vld;
  assign dn_pc     = m_dat.pc;
  assign dn_ins    = m_dat.ins;
  assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench: skid (a_*) and single-entry (b_*) stages driven side by side.
module tb_pipe_stage_hs;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, rdy_in, flush;
  logic a_up_valid, a_up_ready, a_dn_valid, a_dn_ready;
  logic b_up_valid, b_up_ready, b_dn_valid, b_dn_ready;
  logic [31:0] a_up_pc, a_up_ins, a_dn_pc, a_dn_ins;
  logic [31:0] b_up_pc, b_up_ins, b_dn_pc, b_dn_ins;
  logic [1:0]  a_occ, b_occ;

  pipe_stage_hs #(.SKID(1'b1)) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .up_valid(a_up_valid), .up_ready(a_up_ready), .up_pc(a_up_pc), .up_ins(a_up_ins),
    .dn_valid(a_dn_valid), .dn_ready(a_dn_ready), .dn_pc(a_dn_pc), .dn_ins(a_dn_ins),
    .occupancy(a_occ)
  );

  pipe_stage_hs #(.SKID(1'b0)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .up_valid(b_up_valid), .up_ready(b_up_ready), .up_pc(b_up_pc), .up_ins(b_up_ins),
    .dn_valid(b_dn_valid), .dn_ready(b_dn_ready), .dn_pc(b_dn_pc), .dn_ins(b_dn_ins),
    .occupancy(b_occ)
  );

  logic [63:0] a_q[$];
  logic [63:0] b_q[$];
  logic [63:0] a_exp, b_exp;
  int n_tests = 0;
  int n_fail  = 0;
  int a_dn_cnt = 0;
  int b_dn_cnt = 0;
  bit mon_en = 1'b0;
  bit a_upf = 1'b0;
  bit b_upf = 1'b0;

  function automatic logic [31:0] mk_ins(input logic [31:0] pc);
    return {16'hCAFE, pc[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected beat on every downstream transfer.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (rdy_in && a_dn_valid && a_dn_ready) begin
        a_dn_cnt++;
        if (a_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_extra_beat: got pc %h, expected no beat", a_dn_pc);
        end else begin
          a_exp = a_q.pop_front();
          chk("a_dn_pc", a_dn_pc, a_exp[63:32]);
          chk("a_dn_ins", a_dn_ins, a_exp[31:0]);
        end
      end
      if (!a_dn_valid) begin
        chk("a_idle_pc", a_dn_pc, 32'h0);
        chk("a_idle_ins", a_dn_ins, 32'h13);
      end
      if (rdy_in && b_dn_valid && b_dn_ready) begin
        b_dn_cnt++;
        if (b_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_extra_beat: got pc %h, expected no beat", b_dn_pc);
        end else begin
          b_exp = b_q.pop_front();
          chk("b_dn_pc", b_dn_pc, b_exp[63:32]);
          chk("b_dn_ins", b_dn_ins, b_exp[31:0]);
        end
      end
      if (!b_dn_valid) begin
        chk("b_idle_pc", b_dn_pc, 32'h0);
        chk("b_idle_ins", b_dn_ins, 32'h13);
      end
    end
  end

  // One clock: record upstream transfers, then return #1 after the edge.
  task automatic step();
    @(negedge clk_in);
    a_upf = rst_in && !flush && rdy_in && a_up_valid && a_up_ready;
    b_upf = rst_in && !flush && rdy_in && b_up_valid && b_up_ready;
    if (a_upf) a_q.push_back({a_up_pc, a_up_ins});
    if (b_upf) b_q.push_back({b_up_pc, b_up_ins});
    @(posedge clk_in);
    #1;
    if (flush || !rst_in) begin
      a_q.delete();
      b_q.delete();
    end
  endtask

  task automatic a_send(input logic [31:0] pc);
    int n = 0;
    a_up_valid = 1'b1; a_up_pc = pc; a_up_ins = mk_ins(pc);
    do begin step(); n++; end while (!a_upf && n < 20);
    if (!a_upf) begin
      n_tests++; n_fail++;
      $display("FAIL a_send_timeout: pc %h not accepted, expected accept within 20 cycles", pc);
    end
    a_up_valid = 1'b0;
  endtask

  task automatic b_send(input logic [31:0] pc);
    int n = 0;
    b_up_valid = 1'b1; b_up_pc = pc; b_up_ins = mk_ins(pc);
    do begin step(); n++; end while (!b_upf && n < 20);
    if (!b_upf) begin
      n_tests++; n_fail++;
      $display("FAIL b_send_timeout: pc %h not accepted, expected accept within 20 cycles", pc);
    end
    b_up_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    logic [31:0] a_pcn, b_pcn;
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
    a_up_valid = 1'b1; a_up_pc = 32'h100; a_up_ins = mk_ins(32'h100); a_dn_ready = 1'b0;
    b_up_valid = 1'b1; b_up_pc = 32'h100; b_up_ins = mk_ins(32'h100); b_dn_ready = 1'b0;
    repeat (2) step();
    chk("rst_a_dn_valid", 32'(a_dn_valid), 32'd0);
    chk("rst_a_dn_pc", a_dn_pc, 32'h0);
    chk("rst_a_dn_ins", a_dn_ins, 32'h13);
    chk("rst_a_occ", 32'(a_occ), 32'd0);
    chk("rst_a_up_ready", 32'(a_up_ready), 32'd1);
    chk("rst_b_dn_valid", 32'(b_dn_valid), 32'd0);
    chk("rst_b_occ", 32'(b_occ), 32'd0);
    chk("rst_b_up_ready", 32'(b_up_ready), 32'd1);
    rst_in = 1'b1; a_up_valid = 1'b0; b_up_valid = 1'b0;
    mon_en = 1'b1;

    // Streaming through the skid stage
    a_dn_ready = 1'b1;
    cnt0 = a_dn_cnt;
    for (int k = 0; k < 8; k++) begin
      a_up_valid = 1'b1; a_up_pc = 32'(4 * k); a_up_ins = mk_ins(32'(4 * k));
      step();
      chk("stream_upf", 32'(a_upf), 32'd1);
      chk("stream_occ", 32'(a_occ), 32'd1);
      chk("stream_dn_pc", a_dn_pc, 32'(4 * k));
      chk("stream_dn_cnt", 32'(a_dn_cnt - cnt0), 32'(k));
    end
    a_up_valid = 1'b0;
    step();
    chk("stream_total", 32'(a_dn_cnt - cnt0), 32'd8);
    chk("stream_occ_end", 32'(a_occ), 32'd0);

    // Backpressure fills both entries
    a_dn_ready = 1'b0;
    a_send(32'h40);
    chk("bp_occ1", 32'(a_occ), 32'd1);
    a_send(32'h44);
    chk("bp_occ2", 32'(a_occ), 32'd2);
    chk("bp_up_ready", 32'(a_up_ready), 32'd0);
    a_up_valid = 1'b1; a_up_pc = 32'h48; a_up_ins = mk_ins(32'h48);
    step();
    chk("bp_held_upf", 32'(a_upf), 32'd0);
    chk("bp_held_occ", 32'(a_occ), 32'd2);
    chk("bp_held_dn_pc", a_dn_pc, 32'h40);
    a_dn_ready = 1'b1;
    step();
    chk("bp_rel1_dn_pc", a_dn_pc, 32'h44);
    chk("bp_rel1_up_ready", 32'(a_up_ready), 32'd1);
    step();
    chk("bp_rel2_upf", 32'(a_upf), 32'd1);
    chk("bp_rel2_dn_pc", a_dn_pc, 32'h48);
    a_up_valid = 1'b0;
    step();
    chk("bp_drained", 32'(a_q.size()), 32'd0);

    // Flush with both entries full and a beat offered
    a_dn_ready = 1'b0;
    a_send(32'h40);
    a_send(32'h44);
    cnt0 = a_dn_cnt;
    a_up_valid = 1'b1; a_up_pc = 32'h48; a_up_ins = mk_ins(32'h48);
    flush = 1'b1;
    step();
    flush = 1'b0; a_up_valid = 1'b0;
    chk("fl_occ", 32'(a_occ), 32'd0);
    chk("fl_dn_valid", 32'(a_dn_valid), 32'd0);
    chk("fl_dn_pc", a_dn_pc, 32'h0);
    chk("fl_dn_ins", a_dn_ins, 32'h13);
    chk("fl_up_ready", 32'(a_up_ready), 32'd1);
    a_dn_ready = 1'b1;
    repeat (2) step();
    chk("fl_no_output", 32'(a_dn_cnt - cnt0), 32'd0);

    // Flush drops a beat that really handshook
    a_dn_ready = 1'b0;
    a_send(32'h50);
    cnt0 = a_dn_cnt;
    a_up_valid = 1'b1; a_up_pc = 32'h54; a_up_ins = mk_ins(32'h54);
    flush = 1'b1;
    step();
    flush = 1'b0; a_up_valid = 1'b0;
    chk("fl2_occ", 32'(a_occ), 32'd0);
    a_dn_ready = 1'b1;
    repeat (2) step();
    chk("fl2_no_output", 32'(a_dn_cnt - cnt0), 32'd0);

    // Chip-ready freeze mid-stream
    a_send(32'h80);
    a_send(32'h84);
    a_send(32'h88);
    cnt0 = a_dn_cnt;
    a_up_valid = 1'b1; a_up_pc = 32'h8C; a_up_ins = mk_ins(32'h8C);
    rdy_in = 1'b0;
    repeat (3) begin
      step();
      chk("frz_upf", 32'(a_upf), 32'd0);
      chk("frz_dn_pc", a_dn_pc, 32'h88);
      chk("frz_occ", 32'(a_occ), 32'd1);
      chk("frz_dn_cnt", 32'(a_dn_cnt - cnt0), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    chk("frz_resume_upf", 32'(a_upf), 32'd1);
    chk("frz_resume_dn_pc", a_dn_pc, 32'h8C);
    a_up_valid = 1'b0;
    a_send(32'h90);
    step();
    chk("frz_total", 32'(a_dn_cnt - cnt0), 32'd3);
    chk("frz_drained", 32'(a_q.size()), 32'd0);

    // Single-entry stage under backpressure
    b_dn_ready = 1'b0;
    b_send(32'h40);
    chk("b_bp_occ", 32'(b_occ), 32'd1);
    b_up_valid = 1'b1; b_up_pc = 32'h44; b_up_ins = mk_ins(32'h44);
    #1;
    chk("b_bp_up_ready0", 32'(b_up_ready), 32'd0);
    step();
    chk("b_bp_upf", 32'(b_upf), 32'd0);
    chk("b_bp_occ_held", 32'(b_occ), 32'd1);
    b_dn_ready = 1'b1;
    #1;
    chk("b_bp_up_ready1", 32'(b_up_ready), 32'd1);
    step();
    chk("b_rel_upf", 32'(b_upf), 32'd1);
    chk("b_rel_dn_pc", b_dn_pc, 32'h44);
    chk("b_rel_occ", 32'(b_occ), 32'd1);
    b_up_pc = 32'h48; b_up_ins = mk_ins(32'h48);
    step();
    b_up_valid = 1'b0;
    repeat (2) step();
    chk("b_bp_drained", 32'(b_q.size()), 32'd0);

    // Random valid/ready traffic on both stages
    a_pcn = 32'h1000; b_pcn = 32'h2000;
    a_upf = 1'b0; b_upf = 1'b0;
    repeat (1000) begin
      if (!(a_up_valid && !a_upf)) begin
        a_up_valid = 1'($urandom_range(0, 1));
        if (a_up_valid) begin
          a_up_pc = a_pcn; a_up_ins = mk_ins(a_pcn); a_pcn += 32'd4;
        end
      end
      if (!(b_up_valid && !b_upf)) begin
        b_up_valid = 1'($urandom_range(0, 1));
        if (b_up_valid) begin
          b_up_pc = b_pcn; b_up_ins = mk_ins(b_pcn); b_pcn += 32'd4;
        end
      end
      a_dn_ready = 1'($urandom_range(0, 1));
      b_dn_ready = 1'($urandom_range(0, 1));
      rdy_in = ($urandom_range(0, 7) != 0);
      step();
      chk("rnd_a_occ_max", 32'(a_occ == 2'd3), 32'd0);
      chk("rnd_b_occ_max", 32'(b_occ > 2'd1), 32'd0);
      chk("rnd_b_up_ready", 32'(b_up_ready), 32'(!b_dn_valid || b_dn_ready));
    end
    rdy_in = 1'b1;
    a_up_valid = 1'b0; b_up_valid = 1'b0;
    a_dn_ready = 1'b1; b_dn_ready = 1'b1;
    repeat (4) step();
    chk("rnd_a_drained", 32'(a_q.size()), 32'd0);
    chk("rnd_b_drained", 32'(b_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
